// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared stage indices and default sizes for the parametrised pipeline controller.
// Optional watchdog is enabled by defining PIPE_STALL_WATCHDOG_EN (undefined by default).
package pipe_ctrl_gen_pkg;

    typedef enum logic [2:0] {
        STG_PC      = 3'd0,
        STG_IF_ID   = 3'd1,
        STG_ID_EXE  = 3'd2,
        STG_EXE_MEM = 3'd3,
        STG_MEM_WB  = 3'd4
    } stage_e;

    localparam int DEF_NUM_STAGES = 6;
    localparam int DEF_JUMP_STAGE = int'(STG_ID_EXE);
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_WDOG_LIMIT = 1024;

    function automatic int run_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_if.sv
// Bus between the pipeline datapath (master) and the pipeline controller (slave).
interface pipe_ctrl_gen_if
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
    logic [NUM_STAGES-1:0] stallreq_i;
    logic                  jump_valid_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  halt_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] bubble_o;
    logic [NUM_STAGES-1:0] flush_o;
    logic                  new_pc_valid_o;
    logic [ADDR_WIDTH-1:0] new_pc_o;
    logic                  halt_o;
    logic [CNT_WIDTH-1:0]  stall_cnt_o;
    logic                  wdog_err_o;

    modport master (
        output stallreq_i, jump_valid_i, jump_addr_i, halt_i,
        input  stall_o, bubble_o, flush_o, new_pc_valid_o, new_pc_o,
               halt_o, stall_cnt_o, wdog_err_o
    );

    modport slave (
        input  stallreq_i, jump_valid_i, jump_addr_i, halt_i,
        output stall_o, bubble_o, flush_o, new_pc_valid_o, new_pc_o,
               halt_o, stall_cnt_o, wdog_err_o
    );
endinterface

// File: rtl/pipe_ctrl_gen_redirect_q.sv
// Redirect queue: holds a redirect while the PC register is stalled and
// suppresses the re-asserted request of a branch that stays resident.
module pipe_redirect_q
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fresh,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  stall_pc,
    input  logic                  stall_jump,
    output logic                  taken,
    output logic                  new_pc_valid,
    output logic [ADDR_WIDTH-1:0] new_pc
);
    logic                  pending;
    logic [ADDR_WIDTH-1:0] pending_addr;
    logic                  take_now;
    logic                  release_now;

    always_comb begin
        take_now     = fresh & ~stall_pc;
        release_now  = rst_n & pending & ~stall_pc;
        new_pc_valid = take_now | release_now;
        new_pc       = '0;
        if (take_now) begin
            new_pc = jump_addr;
        end else if (release_now) begin
            new_pc = pending_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            pending_addr <= '0;
            taken        <= 1'b0;
        end else begin
            // A fresh request always overwrites whatever was pending.
            if (fresh && stall_pc) begin
                pending      <= 1'b1;
                pending_addr <= jump_addr;
            end else if (!stall_pc) begin
                pending <= 1'b0;
            end
            if (fresh && stall_jump) begin
                taken <= 1'b1;
            end else if (!stall_jump) begin
                taken <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline controller: stall/bubble/flush mask generation, sticky halt, stall counter.
// Define PIPE_STALL_WATCHDOG_EN to build the continuous-stall watchdog.
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int JUMP_STAGE = DEF_JUMP_STAGE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pipe_ctrl_gen_if.slave bus
);
    logic [NUM_STAGES-1:0] stall_arb;
    logic [NUM_STAGES-1:0] bubble_arb;
    logic [NUM_STAGES-1:0] stall_pre;
    logic [NUM_STAGES-1:0] bubble_pre;
    logic [NUM_STAGES-1:0] flush;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic                  acc;
    logic                  halt_q;
    logic                  wdog_err;
    logic                  halted;
    logic                  taken;
    logic                  fresh;
    logic                  new_pc_valid;
    logic [ADDR_WIDTH-1:0] new_pc;

    // Every stage at or below the highest requester holds.
    always_comb begin
        stall_arb = '0;
        acc       = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            acc          = acc | bus.stallreq_i[k];
            stall_arb[k] = acc;
        end
    end

    assign bubble_arb = {stall_arb[NUM_STAGES-2:0], 1'b0} & ~stall_arb;
    assign halted     = halt_q | wdog_err;
    assign fresh      = rst_i & bus.jump_valid_i & ~taken & ~halted;

    always_comb begin
        stall_pre  = '0;
        bubble_pre = '0;
        if (rst_i) begin
            if (halted) begin
                stall_pre = '1;
            end else begin
                stall_pre  = stall_arb;
                bubble_pre = bubble_arb;
            end
        end
    end

    always_comb begin
        flush = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (fresh && k <= JUMP_STAGE) begin
                flush[k] = 1'b1;
            end
        end
    end

    pipe_redirect_q #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_redirect_q (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .fresh        (fresh),
        .jump_addr    (bus.jump_addr_i),
        .stall_pc     (stall_pre[0]),
        .stall_jump   (stall_pre[JUMP_STAGE]),
        .taken        (taken),
        .new_pc_valid (new_pc_valid),
        .new_pc       (new_pc)
    );

    assign bus.stall_o        = stall_pre & ~flush;
    assign bus.bubble_o       = bubble_pre & ~flush;
    assign bus.flush_o        = flush;
    assign bus.new_pc_valid_o = new_pc_valid;
    assign bus.new_pc_o       = new_pc;
    assign bus.halt_o         = rst_i & halted;
    assign bus.stall_cnt_o    = rst_i ? stall_cnt : '0;
    assign bus.wdog_err_o     = rst_i & wdog_err;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            halt_q    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (bus.halt_i) begin
                halt_q <= 1'b1;
            end
            if (stall_pre[0] && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

`ifdef PIPE_STALL_WATCHDOG_EN
    localparam int RUN_W = run_width(WDOG_LIMIT);
    logic [RUN_W-1:0] run_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            run_cnt  <= '0;
            wdog_err <= 1'b0;
        end else if (stall_pre[0] && !halted) begin
            run_cnt <= run_cnt + 1'b1;
            if (run_cnt == RUN_W'(WDOG_LIMIT - 1)) begin
                wdog_err <= 1'b1;
            end
        end else begin
            run_cnt <= '0;
        end
    end
`else
    assign wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen: per-cycle spec model plus directed literal checks.
module tb_pipe_ctrl_gen;
    localparam int N  = 6;
    localparam int J  = 2;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int WL = 8;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    pipe_ctrl_gen_if #(.NUM_STAGES(N), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    pipe_ctrl_gen #(
        .NUM_STAGES (N),
        .JUMP_STAGE (J),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .WDOG_LIMIT (WL)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state, committed at each rising edge.
    bit          m_pending = 0, m_taken = 0, m_halt = 0, m_wdog = 0;
    logic [31:0] m_paddr = '0;
    int          m_cnt = 0, m_run = 0;
    bit          n_pending, n_taken, n_halt, n_wdog;
    logic [31:0] n_paddr;
    int          n_cnt, n_run;

    always @(negedge clk) begin : compare
        int h, es, eb, ef, so, bo;
        bit halted, fresh, pcs, js, ev;
        logic [31:0] ea;
        h = -1;
        for (int k = 0; k < N; k++) if (bus.stallreq_i[k]) h = k;
        halted = m_halt || m_wdog;
        es = 0; eb = 0; ef = 0; ev = 0; ea = '0;
        n_pending = 0; n_taken = 0; n_halt = 0; n_wdog = 0; n_paddr = '0; n_cnt = 0; n_run = 0;
        if (rst) begin
            if (halted) es = (1 << N) - 1;
            else if (h >= 0) begin
                es = (1 << (h + 1)) - 1;
                if (h + 1 < N) eb = 1 << (h + 1);
            end
            fresh = bus.jump_valid_i && !m_taken && !halted;
            if (fresh) ef = (1 << (J + 1)) - 2;
            pcs = es[0];
            js  = es[J];
            if (fresh && !pcs) begin ev = 1; ea = bus.jump_addr_i; end
            else if (m_pending && !pcs) begin ev = 1; ea = m_paddr; end
            n_pending = m_pending; n_paddr = m_paddr;
            if (fresh && pcs) begin n_pending = 1; n_paddr = bus.jump_addr_i; end
            else if (!pcs) n_pending = 0;
            n_taken = m_taken;
            if (fresh && js) n_taken = 1;
            else if (!js) n_taken = 0;
            n_halt = m_halt || bus.halt_i;
            n_cnt = (pcs && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            n_wdog = m_wdog;
`ifdef PIPE_STALL_WATCHDOG_EN
            if (pcs && !halted) begin
                n_run = m_run + 1;
                if (n_run >= WL) n_wdog = 1;
            end
`endif
        end
        so = es & ~ef;
        bo = eb & ~ef;
        checkOutput("stall", bus.stall_o, 64'(so));
        checkOutput("bubble", bus.bubble_o, 64'(bo));
        checkOutput("flush", bus.flush_o, 64'(ef));
        checkOutput("new_pc_valid", bus.new_pc_valid_o, 64'(ev));
        checkOutput("new_pc", bus.new_pc_o, 64'(ea));
        checkOutput("halt", bus.halt_o, 64'(rst && halted));
        checkOutput("stall_cnt", bus.stall_cnt_o, rst ? 64'(m_cnt) : 64'd0);
        checkOutput("wdog_err", bus.wdog_err_o, 64'(rst && m_wdog));
    end

    always @(posedge clk) begin
        m_pending = n_pending; m_taken = n_taken; m_halt = n_halt; m_wdog = n_wdog;
        m_paddr = n_paddr; m_cnt = n_cnt; m_run = n_run;
    end

    task automatic applyStimulus(input bit r, input logic [N-1:0] req, input bit jv,
                                 input logic [31:0] a, input bit hl);
        @(posedge clk);
        #1;
        rst              = r;
        bus.stallreq_i   = req;
        bus.jump_valid_i = jv;
        bus.jump_addr_i  = a;
        bus.halt_i       = hl;
    endtask

    initial begin
        rst = 1'b0;
        bus.stallreq_i = '0; bus.jump_valid_i = 1'b0; bus.jump_addr_i = '0; bus.halt_i = 1'b0;

        // Reset held with a stall request present
        for (int i = 0; i < 3; i++) applyStimulus(0, 6'b001000, 0, 32'h0, 0);
        #2;
        checkOutput("lit_reset_stall", bus.stall_o, 64'h0);
        checkOutput("lit_reset_bubble", bus.bubble_o, 64'h0);
        applyStimulus(1, 6'b001000, 0, 32'h0, 0);
        #2;
        checkOutput("lit_release_stall", bus.stall_o, 64'b001111);
        checkOutput("lit_release_bubble", bus.bubble_o, 64'b010000);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);

        // Immediate redirect
        applyStimulus(1, 6'b000000, 1, 32'h0000_0100, 0);
        #2;
        checkOutput("lit_imm_valid", bus.new_pc_valid_o, 64'h1);
        checkOutput("lit_imm_pc", bus.new_pc_o, 64'h100);
        checkOutput("lit_imm_flush", bus.flush_o, 64'b000110);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);

        // Deferred redirect from a stalled branch
        applyStimulus(1, 6'b000100, 1, 32'h0000_0200, 0);
        #2;
        checkOutput("lit_def_flush1", bus.flush_o, 64'b000110);
        checkOutput("lit_def_valid1", bus.new_pc_valid_o, 64'h0);
        applyStimulus(1, 6'b000100, 1, 32'h0000_0200, 0);
        #2;
        checkOutput("lit_def_flush2", bus.flush_o, 64'h0);
        checkOutput("lit_def_stall2", bus.stall_o, 64'b000111);
        applyStimulus(1, 6'b000100, 1, 32'h0000_0200, 0);
        applyStimulus(1, 6'b000000, 1, 32'h0000_0200, 0);
        #2;
        checkOutput("lit_def_valid", bus.new_pc_valid_o, 64'h1);
        checkOutput("lit_def_pc", bus.new_pc_o, 64'h200);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);
        #2;
        checkOutput("lit_def_after", bus.new_pc_valid_o, 64'h0);

        // Fresh request overwrites a pending one on its release cycle
        applyStimulus(1, 6'b000001, 1, 32'h0000_0200, 0);
        applyStimulus(1, 6'b000000, 1, 32'h0000_0300, 0);
        #2;
        checkOutput("lit_ovr_pc", bus.new_pc_o, 64'h300);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);
        #2;
        checkOutput("lit_ovr_after", bus.new_pc_valid_o, 64'h0);

        // Stall above the jump stage together with a redirect
        applyStimulus(1, 6'b010000, 1, 32'h0000_0400, 0);
        #2;
        checkOutput("lit_mix_stall", bus.stall_o, 64'b011001);
        checkOutput("lit_mix_bubble", bus.bubble_o, 64'b100000);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);
        #2;
        checkOutput("lit_mix_pc", bus.new_pc_o, 64'h400);

        // Counter saturation, stall runs kept short of the watchdog limit
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 6; i++) applyStimulus(1, 6'b000001, 0, 32'h0, 0);
            applyStimulus(1, 6'b000000, 0, 32'h0, 0);
        end
        #2;
        checkOutput("lit_cnt_sat", bus.stall_cnt_o, 64'hF);

        // Reset asserted mid-pending
        applyStimulus(1, 6'b000100, 1, 32'h0000_0500, 0);
        applyStimulus(0, 6'b000100, 1, 32'h0000_0500, 0);
        #2;
        checkOutput("lit_rstmid_valid", bus.new_pc_valid_o, 64'h0);
        checkOutput("lit_rstmid_cnt", bus.stall_cnt_o, 64'h0);
        applyStimulus(0, 6'b000100, 1, 32'h0000_0500, 0);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);
        #2;
        checkOutput("lit_rstmid_release", bus.new_pc_valid_o, 64'h0);

        // Sticky halt
        applyStimulus(1, 6'b000000, 0, 32'h0, 1);
        #2;
        checkOutput("lit_halt_before", bus.halt_o, 64'h0);
        applyStimulus(1, 6'b000000, 1, 32'h0000_0600, 0);
        #2;
        checkOutput("lit_halt_set", bus.halt_o, 64'h1);
        checkOutput("lit_halt_stall", bus.stall_o, 64'b111111);
        checkOutput("lit_halt_nojump", bus.new_pc_valid_o, 64'h0);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);

`ifdef PIPE_STALL_WATCHDOG_EN
        // Continuous stall reaching the watchdog limit
        applyStimulus(0, 6'b000000, 0, 32'h0, 0);
        applyStimulus(0, 6'b000000, 0, 32'h0, 0);
        for (int i = 0; i < WL; i++) applyStimulus(1, 6'b000010, 0, 32'h0, 0);
        #2;
        checkOutput("lit_wdog_before", bus.wdog_err_o, 64'h0);
        applyStimulus(1, 6'b000010, 0, 32'h0, 0);
        #2;
        checkOutput("lit_wdog_err", bus.wdog_err_o, 64'h1);
        checkOutput("lit_wdog_halt", bus.halt_o, 64'h1);
        checkOutput("lit_wdog_cnt", bus.stall_cnt_o, 64'h8);
`endif

        applyStimulus(1, 6'b000000, 0, 32'h0, 0);
        applyStimulus(1, 6'b000000, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
- Parametrised pipeline controller for the RV32 core; successor to the fixed 6-bit-stall pipe_ctrl.
- Arbitrates per-stage stall requests into per-stage stall and bubble masks.
- Accepts branch/jump redirects from a configurable resolving stage and holds a redirect pending while the PC register is stalled.
- Suppresses duplicate redirects from a stalled branch, latches the ISA-test halt, and counts stall cycles.

Parameters:
- NUM_STAGES, 6, pipeline positions; index 0 = pc_reg, 1 = if_id, 2 = id_exe, 3 = exe_mem, 4 = mem_wb, 5 = spare/WB.
- JUMP_STAGE, 2, index of the stage whose instruction resolves jumps (the exe input register); 1 ≤ JUMP_STAGE < NUM_STAGES.
- ADDR_WIDTH, 32, PC width.
- CNT_WIDTH, 16, stall-cycle counter width.
- WDOG_LIMIT, 1024, continuous-stall watchdog threshold (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous and active-low.
- stallreq_i  in  NUM_STAGES  stall request, bit k raised by the logic consuming stage k's register.
- jump_valid_i  in  1  redirect request from stage JUMP_STAGE.
- jump_addr_i  in  ADDR_WIDTH  redirect target.
- halt_i  in  1  halt indication from mem (ISA test end).
- stall_o  out  NUM_STAGES  hold mask; bit k freezes stage k's register.
- bubble_o  out  NUM_STAGES  insert-NOP mask.
- flush_o  out  NUM_STAGES  redirect flush mask.
- new_pc_valid_o  out  1  PC load strobe.
- new_pc_o  out  ADDR_WIDTH  PC load value.
- halt_o  out  1  sticky halt.
- stall_cnt_o  out  CNT_WIDTH  saturating total of cycles with stall_o[0]=1.
- wdog_err_o  out  1  sticky watchdog error; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst_i=0 at a clk_i edge) clears all registered state: pending flag, pending address, taken flag, halt, counter, watchdog.
- All outputs read 0 while reset is held low; this applies equally if reset is asserted mid-stall or mid-pending.
- Stall resolution is combinational, same cycle:
  - h = highest index with stallreq_i[h]=1.
  - stall_o[k]=1 for k ≤ h.
  - bubble_o[h+1]=1 when h+1 < NUM_STAGES.
  - With no request, stall_o=0 and bubble_o=0.
- Halt:
  - halt_i=1 sets halt_o at the next edge; halt_o stays set until reset.
  - While halt_o=1: stall_o is all ones, bubble_o=0, and redirects are ignored.
- Redirect acceptance, fresh request:
  - A fresh request is jump_valid_i=1 with taken=0 and halt_o=0.
  - The same cycle, flush_o[k]=1 for 1 ≤ k ≤ JUMP_STAGE; flush overrides stall for those stages.
  - If stall_o[0]=0: new_pc_valid_o=1 and new_pc_o=jump_addr_i, combinational, zero latency.
  - If stall_o[0]=1: pending_addr←jump_addr_i and pending←1 at the edge.
- Pending release:
  - The first cycle with pending=1 and stall_o[0]=0 drives new_pc_valid_o=1 and new_pc_o=pending_addr.
  - pending clears at that edge.
- Duplicate suppression (taken flag):
  - taken←1 when a redirect is accepted while stall_o[JUMP_STAGE]=1, because the branch stays resident and jump_valid_i re-asserts.
  - taken clears at the first edge with stall_o[JUMP_STAGE]=0.
  - While taken=1, jump_valid_i is ignored.
- Simultaneous events:
  - A fresh request in the same cycle as a pending release: the fresh request wins and overwrites pending.
  - stallreq_i and a redirect together: flush wins for stages 1..JUMP_STAGE; stages above JUMP_STAGE keep their stall/bubble values.
- Idle outputs: new_pc_o=0 whenever new_pc_valid_o=0.
- Counter: stall_cnt_o increments on every cycle with stall_o[0]=1 and saturates at all ones (no wrap).

Optional Feature:
- Macro: PIPE_STALL_WATCHDOG_EN.
- When defined:
  - A run counter counts consecutive cycles with stall_o[0]=1 and halt_o=0; it clears on any non-stalled cycle.
  - When the run count reaches WDOG_LIMIT, wdog_err_o←1 (sticky until reset) and halt_o is forced to 1.
- When undefined: no run counter is built and wdog_err_o is tied to 0.

Decomposition:
- defines.v gains:
  - stage index constants STG_PC, STG_IF_ID, STG_ID_EXE, STG_EXE_MEM, STG_MEM_WB;
  - ADDR_WIDTH reuse;
  - PIPE_STALL_WATCHDOG_EN, default undefined.
- One sub-module: pipe_redirect_q. It holds the pending/taken flags and the pending address and produces the new_pc strobe and value.
- Mask generation and the counters remain in the top.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with stallreq_i=6'b001000 → all outputs 0; release → stall_o=6'b001111, bubble_o=6'b010000.
- Immediate redirect: stallreq_i=0, jump_valid_i=1, addr=0x0000_0100 → same cycle new_pc_valid_o=1, new_pc_o=0x100, flush_o=6'b000110.
- Deferred redirect: stallreq_i=6'b000100 for 3 cycles with jump_valid_i=1 and addr=0x200, then release:
  - exactly one flush pulse in the first cycle, then no new flush/redirect while the stall holds;
  - new_pc_valid_o pulses once, in the release cycle, with 0x200.
- Overwrite: pending=0x200 and, on the release cycle, a fresh jump to 0x300 → a single strobe with 0x300, and pending clears.
- Halt: halt_i pulse for 1 cycle → halt_o=1 from the next cycle; stall_o=6'b111111 thereafter; a later jump_valid_i produces no strobe.
- Watchdog (macro defined, WDOG_LIMIT=8): stallreq_i[1]=1 continuously → wdog_err_o=1 and halt_o=1 after the 8th stalled cycle; stall_cnt_o=8.
